// File: rtl/dsm_pkg.sv
// -----------------------------------------------------------------------------
// dsm_pkg
// Shared definitions for the ternary delta-sigma link: PWM code points, the
// decoder used on the receive side, a saturation helper and the settle-FSM
// state type used by the CIC decimator.
// No ports (package).
// -----------------------------------------------------------------------------
package dsm_pkg;

  localparam logic [1:0] PWM_ZERO = 2'b00;
  localparam logic [1:0] PWM_POS  = 2'b01;
  localparam logic [1:0] PWM_NEG  = 2'b11;

  // Decoded PWM symbol: val is a 2-bit two's-complement value (-1, 0, +1).
  typedef struct packed {
    logic [1:0] val;
    logic       illegal;
  } pwm_dec_t;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } settle_state_e;

  // Code 2'b10 has no meaning on the link; it is treated as a zero sample
  // and flagged so the caller can latch an error.
  function automatic pwm_dec_t pwm_decode(input logic [1:0] code);
    pwm_dec_t r;
    r.val     = 2'b00;
    r.illegal = 1'b0;
    case (code)
      PWM_ZERO: r.val = 2'b00;
      PWM_POS:  r.val = 2'b01;
      PWM_NEG:  r.val = 2'b11;
      default:  r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  // Clamp a signed value into the range of a signed 'bits'-wide word.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int                 bits);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/dsm_cic_decimator_if.sv
// -----------------------------------------------------------------------------
// dsm_cic_decimator_if
// Sample-stream bundle between a PWM source and the CIC decimator.
//   in_en      : input sample strobe (source -> decimator)
//   pwm        : 2-bit ternary code (source -> decimator)
//   dout       : signed decimated sample, held between updates
//   dout_valid : one-cycle pulse when dout updates (after settling)
//   code_err   : sticky illegal-code flag
// master = stream source / consumer of results, slave = decimator.
// -----------------------------------------------------------------------------
interface dsm_cic_decimator_if #(
  parameter int OUT_BITS = 15
);
  logic                       in_en;
  logic [1:0]                 pwm;
  logic signed [OUT_BITS-1:0] dout;
  logic                       dout_valid;
  logic                       code_err;

  modport master (
    output in_en, pwm,
    input  dout, dout_valid, code_err
  );

  modport slave (
    input  in_en, pwm,
    output dout, dout_valid, code_err
  );
endinterface

// File: rtl/cic_comb_stage.sv
// -----------------------------------------------------------------------------
// cic_comb_stage
// One CIC comb section: on each enabled edge it registers din - delay and then
// remembers din as the new delay. Arithmetic wraps modulo 2^W on purpose.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   en_i   : advance the stage (one pulse per decimated sample)
//   din_i  : input from the previous comb stage
//   dout_o : registered difference
// -----------------------------------------------------------------------------
module cic_comb_stage #(
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [W-1:0] diff_q;
  logic [W-1:0] delay_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      diff_q  <= '0;
      delay_q <= '0;
    end else if (en_i) begin
      diff_q  <= din_i - delay_q;
      delay_q <= din_i;
    end
  end

  assign dout_o = diff_q;

endmodule

// File: rtl/dsm_cic_decimator.sv
// -----------------------------------------------------------------------------
// dsm_cic_decimator
// Decodes the ternary PWM stream and decimates it by R = 2^DEC_LOG2 through an
// ORDER-stage CIC filter, producing a saturated signed OUT_BITS sample.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of dsm_cic_decimator_if (in_en, pwm in;
//           dout, dout_valid, code_err out)
// dout/dout_valid change on the edge ORDER cycles after a decimation tick.
// -----------------------------------------------------------------------------
module dsm_cic_decimator
  import dsm_pkg::*;
#(
  parameter int ORDER    = 3,
  parameter int DEC_LOG2 = 5,
  parameter int OUT_BITS = 15
) (
  input  logic            clock,
  input  logic            reset,
  dsm_cic_decimator_if.slave bus
);

  localparam int W     = ORDER * DEC_LOG2 + 2;
  localparam int SHIFT = ORDER * DEC_LOG2 + 1 - OUT_BITS;
  localparam int CW    = $clog2(ORDER + 1);

  pwm_dec_t               dec;
  logic [W-1:0]           x;
  logic                   tick;
  logic [DEC_LOG2-1:0]    phase_q;
  logic [W-1:0]           integ_q [ORDER];
  logic [ORDER:1]         tick_pipe_q;
  logic [ORDER:0][W-1:0]  comb_data;
  logic signed [W-1:0]    comb_last;
  logic                   code_err_q;
  logic                   dout_valid_q, dout_valid_d;
  settle_state_e          state_q, state_d;
  logic [CW-1:0]          settle_cnt_q, settle_cnt_d;

  assign dec  = pwm_decode(bus.pwm);
  assign x    = {{(W-2){dec.val[1]}}, dec.val};
  assign tick = bus.in_en && (phase_q == '1);

  // Phase counter wraps naturally because R is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q    <= '0;
      code_err_q <= 1'b0;
    end else if (bus.in_en) begin
      phase_q <= phase_q + DEC_LOG2'(1);
      if (dec.illegal) begin
        code_err_q <= 1'b1;
      end
    end
  end

  // Pipelined integrator chain: every stage adds the pre-edge value of the
  // stage before it, so stage k lags the input by k-1 samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      integ_q <= '{default: '0};
    end else if (bus.in_en) begin
      integ_q[0] <= integ_q[0] + x;
      for (int k = 1; k < ORDER; k++) begin
        integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
    end
  end

  // comb_data[0] holds the decimated integrator output; tick_pipe_q[j] walks
  // the tick down the comb chain, one stage per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      comb_data[0] <= '0;
      tick_pipe_q  <= '0;
    end else begin
      tick_pipe_q <= ORDER'({tick_pipe_q, tick});
      if (tick) begin
        comb_data[0] <= integ_q[ORDER-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ORDER; gi++) begin : g_comb
      cic_comb_stage #(.W(W)) u_comb (
        .clock  (clock),
        .reset  (reset),
        .en_i   (tick_pipe_q[gi+1]),
        .din_i  (comb_data[gi]),
        .dout_o (comb_data[gi+1])
      );
    end
  endgenerate

  // Settle FSM: the first ORDER outputs come from a partially filled comb
  // history, so they update dout but are not flagged valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    dout_valid_d = 1'b0;
    if (tick_pipe_q[ORDER]) begin
      case (state_q)
        SETTLE: begin
          settle_cnt_d = settle_cnt_q + CW'(1);
          if (settle_cnt_q == CW'(ORDER - 1)) begin
            state_d = RUN;
          end
        end
        RUN:     dout_valid_d = 1'b1;
        default: state_d = SETTLE;
      endcase
    end
  end

  // The last comb register only moves on the tick pipeline, so scaling it
  // combinationally yields a held output aligned with dout_valid.
  assign comb_last      = $signed(comb_data[ORDER]);
  assign bus.dout       = OUT_BITS'(sat_signed(32'(comb_last >>> SHIFT), OUT_BITS));
  assign bus.dout_valid = dout_valid_q;
  assign bus.code_err   = code_err_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Bench for dsm_cic_decimator. Reference: output m is the convolution of the
// accepted samples with the CIC impulse response (R-tap box filter convolved
// ORDER times), taken at the newest sample index m*R+R-1-ORDER, then scaled
// and saturated; it appears ORDER cycles after the tick.
module tb_dsm_cic_decimator;

  localparam int ORDER    = 3;
  localparam int DEC_LOG2 = 5;
  localparam int OUT_BITS = 15;
  localparam int R        = 1 << DEC_LOG2;
  localparam int SHIFT    = ORDER * DEC_LOG2 + 1 - OUT_BITS;
  localparam int HLEN     = ORDER * (R - 1) + 1;
  localparam int OMAX     = (1 << (OUT_BITS - 1)) - 1;
  localparam int OMIN     = -(1 << (OUT_BITS - 1));

  logic clock = 1'b0;
  logic reset = 1'b1;

  dsm_cic_decimator_if #(.OUT_BITS(OUT_BITS)) bus ();

  dsm_cic_decimator #(
    .ORDER    (ORDER),
    .DEC_LOG2 (DEC_LOG2),
    .OUT_BITS (OUT_BITS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks;
  int n_fail;
  int h [HLEN];
  int xs [$];
  int due_q [$];
  int val_q [$];
  bit vld_q [$];
  int cyc;
  int exp_dout;
  bit exp_valid;
  bit exp_err;
  int first_valid_cyc;
  int last_valid_cyc;
  int cap_sel;
  int seq_a [$];
  int seq_b [$];
  logic [1:0] rec_codes [$];

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) begin
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
    end
  endtask

  task automatic build_h();
    int tmp [HLEN];
    int len;
    len = 1;
    foreach (h[i]) h[i] = 0;
    h[0] = 1;
    repeat (ORDER) begin
      foreach (tmp[i]) tmp[i] = 0;
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < R; k++) begin
          tmp[i+k] += h[i];
        end
      end
      h = tmp;
      len += R - 1;
    end
  endtask

  function automatic int cic_expect(input int m);
    int q;
    int y;
    int c;
    q = m * R + R - 1 - ORDER;
    y = 0;
    for (int k = 0; k < HLEN; k++) begin
      if (q - k >= 0) y += h[k] * xs[q-k];
    end
    c = y >>> SHIFT;
    if (c > OMAX) c = OMAX;
    if (c < OMIN) c = OMIN;
    return c;
  endfunction

  task automatic model_reset();
    xs.delete();
    due_q.delete();
    val_q.delete();
    vld_q.delete();
    cyc = 0;
    exp_dout = 0;
    exp_valid = 1'b0;
    exp_err = 1'b0;
    first_valid_cyc = -1;
    last_valid_cyc = -1;
  endtask

  // One clock: drive, let the edge consume, update the model, compare at negedge.
  task automatic step(input bit en, input logic [1:0] code);
    int x;
    int m;
    bus.in_en = en;
    bus.pwm   = code;
    @(posedge clock);
    cyc++;
    exp_valid = 1'b0;
    if (en) begin
      case (code)
        2'b01:   x = 1;
        2'b11:   x = -1;
        2'b10:   begin x = 0; exp_err = 1'b1; end
        default: x = 0;
      endcase
      xs.push_back(x);
      if (xs.size() % R == 0) begin
        m = xs.size() / R - 1;
        due_q.push_back(cyc + ORDER);
        val_q.push_back(cic_expect(m));
        vld_q.push_back(m >= ORDER);
      end
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      exp_dout  = val_q.pop_front();
      exp_valid = vld_q.pop_front();
    end
    @(negedge clock);
    check_val("dout_valid", bus.dout_valid, exp_valid);
    check_val("dout", bus.dout, exp_dout);
    check_val("code_err", bus.code_err, exp_err);
    if (bus.dout_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (last_valid_cyc >= 0) check_val("valid_gap_ge_R", (cyc - last_valid_cyc) >= R, 1);
      last_valid_cyc = cyc;
      if (cap_sel == 1) seq_a.push_back(bus.dout);
      else if (cap_sel == 2) seq_b.push_back(bus.dout);
    end
  endtask

  // mode: 0 zeros, 1 +1, 2 -1, 3 alt +1/0, 4 alt +1/-1, 5 random (recorded), 6 replay
  task automatic run(input int nsamp, input int mode, input int idle_pct, input int inject_at);
    int a;
    int r;
    bit en;
    logic [1:0] code;
    a = 0;
    while (a < nsamp) begin
      en = ($urandom_range(99) >= idle_pct);
      if (en) begin
        case (mode)
          0: code = 2'b00;
          1: code = 2'b01;
          2: code = 2'b11;
          3: code = (a % 2 == 0) ? 2'b01 : 2'b00;
          4: code = (a % 2 == 0) ? 2'b01 : 2'b11;
          5: begin
            r = $urandom_range(2);
            code = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            rec_codes.push_back(code);
          end
          6: code = rec_codes[a];
          default: code = 2'b00;
        endcase
        if (a == inject_at) code = 2'b10;
        a++;
      end else begin
        code = 2'($urandom_range(3));
      end
      step(en, code);
    end
  endtask

  // Called at a negedge; holds reset across one rising edge.
  task automatic do_reset();
    reset = 1'b0;
    bus.in_en = 1'b0;
    #1;
    check_val("rst_dout", bus.dout, 0);
    check_val("rst_valid", bus.dout_valid, 0);
    check_val("rst_code_err", bus.code_err, 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    cap_sel = 0;
    bus.in_en = 1'b0;
    bus.pwm = 2'b00;
    build_h();
    model_reset();
    @(negedge clock);
    do_reset();

    run(10 * R, 0, 0, -1);
    check_val("first_valid_cycle", first_valid_cyc, 4 * R + 3);
    check_val("steady_zero", bus.dout, 0);
    run(8 * R, 1, 0, -1);
    check_val("steady_pos", bus.dout, 16383);
    run(8 * R, 2, 0, -1);
    check_val("steady_neg", bus.dout, -16384);
    run(8 * R, 3, 0, -1);
    check_val("steady_half", bus.dout, 8192);
    run(8 * R, 4, 0, -1);
    check_val("steady_alt", bus.dout, 0);
    run(6 * R, 1, 0, 100);
    check_val("code_err_sticky", bus.code_err, 1);

    // Run ended on a tick; one more sample, then reset with a sample in flight.
    step(1'b1, 2'b01);
    do_reset();
    run(6 * R, 1, 30, -1);

    do_reset();
    cap_sel = 1;
    run(12 * R, 5, 0, -1);
    repeat (ORDER + 2) step(1'b0, 2'b00);
    do_reset();
    cap_sel = 2;
    run(12 * R, 6, 50, -1);
    repeat (ORDER + 2) step(1'b0, 2'b00);
    cap_sel = 0;
    check_val("gap_seq_len_a", seq_a.size(), 12 - ORDER);
    check_val("gap_seq_len_b", seq_b.size(), seq_a.size());
    for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++) begin
      check_val("gap_seq", seq_b[i], seq_a[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsm_cic_decimator.md
# dsm_cic_decimator

Receive-side decoder for the ternary delta-sigma bitstream produced by the modulator. It accepts the 2-bit PWM code (0 / +1 / −1) at the modulator rate and reconstructs a multi-bit signed sample every R input samples. The filter is an N-stage CIC (Hogenauer) decimator with a saturating output scaler. It sits downstream of the modulator output register, in loopback/verification builds or on the far end of the PWM link.

## Interface
- `ORDER`, default 3: number of CIC integrator/comb stages N; allowed range 1..4.
- `DEC_LOG2`, default 5: decimation ratio R = 2^DEC_LOG2; R > ORDER is required.
- `OUT_BITS`, default 15: output sample width (T_BITS); ORDER*DEC_LOG2+1 ≥ OUT_BITS is required.
- `clock`  input  1  single clock; all state is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in_en`  input  1  input sample strobe; `pwm` is consumed only when high.
- `pwm`  input  2  ternary code: 2'b00 = 0, 2'b01 = +1, 2'b11 = −1, 2'b10 = illegal.
- `dout`  output  OUT_BITS  signed decimated sample, held between updates.
- `dout_valid`  output  1  one-cycle pulse when `dout` updates.
- `code_err`  output  1  sticky flag; set by any illegal code accepted with `in_en` high.

## Operation
- Internal width W = ORDER*DEC_LOG2 + 2. All integrator and comb arithmetic is two's-complement modulo 2^W, and wrap-around is intended. CIC gain is R^N, so comb results are exact despite integrator wrap.
- Decode: x = 0, +1 or −1, sign-extended to W. An illegal code decodes as 0 and sets `code_err`.
- Integrators are a pipelined chain, updated only on `in_en` = 1, each using pre-edge values: I1 ← I1 + x; Ik ← Ik + I(k−1).
- Phase counter, DEC_LOG2 bits:
  - Increments on each `in_en`.
  - A decimation tick occurs when `in_en` = 1 and the counter equals R−1; the counter then wraps to 0.
- On a tick edge, the comb input register captures the pre-edge I_N.
- Comb stage j registers on the edge j cycles after the tick. It computes Cj = C(j−1) − delay_j and then loads delay_j ← C(j−1).
- Comb stages advance only on the tick pipeline, not on idle cycles.
- Output scaling: c = C_N arithmetic-shifted right by ORDER*DEC_LOG2+1−OUT_BITS, then saturated to [−2^(OUT_BITS−1), 2^(OUT_BITS−1)−1].
- Settling:
  - A settle counter suppresses `dout_valid` for the first ORDER decimated outputs after reset; `dout` still updates during this period.
  - States: SETTLE (count < ORDER) → RUN. RUN is held until reset.
- Idle gaps in `in_en` have no effect on results. The output sequence depends only on the accepted code sequence.

## Timing
- Reset values:
  - `dout` = 0, `dout_valid` = 0, `code_err` = 0.
  - All integrators, comb delays and the phase counter = 0; settle state = SETTLE.
- Latency: `dout`/`dout_valid` update on the edge ORDER cycles after the tick edge. `dout_valid` is high for exactly one cycle.
- Because R > ORDER and ticks are ≥ R cycles apart, the comb pipeline never carries two samples at once.
- `code_err` is set on the edge that accepts the illegal code and clears only on reset.
- Reset asserted mid-pipeline: all state clears immediately and an in-flight sample is discarded. No `dout_valid` is produced until ORDER+1 ticks after reset release.
- `in_en` low on the would-be tick cycle: the tick is deferred to the next accepted sample.

## Structure
- Shared package `dsm_pkg`:
  - PWM code constants `PWM_ZERO`, `PWM_POS`, `PWM_NEG`.
  - Function `pwm_decode` (code → signed ±1/0 plus an illegal flag).
  - Saturate helper function.
- One sub-module, `cic_comb_stage` (parameter W; registered difference plus delay register, enable input), instantiated ORDER times in a generate loop. Integrators stay inline in the top.

## Test plan
- Default params, all `pwm` = 00 with `in_en` = 1 → first `dout_valid` after 4 ticks (cycle 4*32+3 from release), `dout` = 0 every 32 cycles.
- Constant 01 → steady `dout` = 16383 (CIC value 2^15 → 16384, saturated); constant 11 → steady `dout` = −16384.
- Alternating 01/00 → steady `dout` = 8192; alternating 01/11 → steady 0.
- Same stimulus with `in_en` randomly deasserted 50 % of cycles → `dout` sequence identical to the contiguous run; `dout_valid` spacing ≥ 32 cycles.
- Inject one 10 code inside a constant-01 stream → `code_err` rises on that edge and stays set; the affected output differs from 16383 by the 0-substitution only.
- Assert `reset` low for 1 cycle two cycles after a tick → no `dout_valid` from the in-flight sample, all outputs read 0, SETTLE restarts (4 ticks before the next valid).
